// File: rtl/imem_boot_loader.sv
// Boot loader for the 256-byte instruction memory: packs a byte stream into words, then hands the address port to the core.
// Optional checksum byte after the program when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_boot_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned NUM_WORDS = 64,
    parameter int unsigned LEN_W     = 7
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_load_len,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    input  logic [ADDR_W-1:0] i_cpu_pc,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic              o_imem_we,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_err
);

    localparam int unsigned WCNT_W = ADDR_W - 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_RUN,
        ST_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , ST_CHECK
`endif
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [WCNT_W-1:0]  r_word_cnt;
    logic [1:0]         r_byte_cnt;
    logic [31:0]        r_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         r_xor;
`endif
    logic               r_rx_ready;
    logic               r_imem_we;
    logic               r_cpu_hold;
    logic               r_done;
    logic               r_err;

    logic               w_start_ok;
    logic               w_rx_fire;
    logic               w_last_word;
    logic               w_load;

    assign w_start_ok  = (i_load_len != '0) && (i_load_len <= LEN_W'(NUM_WORDS));
    assign w_rx_fire   = i_rx_valid && r_rx_ready;
    assign w_last_word = (LEN_W'(r_word_cnt) + LEN_W'(1)) == r_len;

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (i_start) begin
                    if (w_start_ok) begin
                        w_state_nxt = ST_RECV;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = ST_ERR;
                    end
                end
            end
            ST_RECV: begin
                if (w_rx_fire && (r_byte_cnt == 2'd3)) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_state_nxt = ST_CHECK;
`else
                    w_state_nxt = ST_RUN;
`endif
                end else begin
                    w_state_nxt = ST_RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (w_rx_fire) begin
                    w_state_nxt = (i_rx_data == r_xor) ? ST_RUN : ST_ERR;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath counters, word assembly and state-decoded registered outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_len      <= '0;
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor      <= '0;
`endif
            r_rx_ready <= 1'b0;
            r_imem_we  <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_load) begin
                r_len      <= i_load_len;
                r_word_cnt <= '0;
                r_byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_xor      <= '0;
`endif
            end else if ((r_state == ST_RECV) && w_rx_fire) begin
                r_word[{r_byte_cnt, 3'b000} +: 8] <= i_rx_data;
                r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_xor      <= r_xor ^ i_rx_data;
`endif
            end else if (r_state == ST_WRITE) begin
                r_byte_cnt <= '0;
                // Cleared after the last word so the loader address never wraps
                r_word_cnt <= w_last_word ? '0 : r_word_cnt + WCNT_W'(1);
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            r_rx_ready <= (w_state_nxt == ST_RECV) || (w_state_nxt == ST_CHECK);
`else
            r_rx_ready <= (w_state_nxt == ST_RECV);
`endif
            r_imem_we  <= (w_state_nxt == ST_WRITE);
            r_cpu_hold <= (w_state_nxt != ST_RUN);
            r_done     <= (w_state_nxt == ST_RUN);
            r_err      <= (w_state_nxt == ST_ERR);
        end
    end

    // Core PC owns the memory port only while running, with zero latency
    assign o_imem_addr  = (r_state == ST_RUN) ? i_cpu_pc : {r_word_cnt, 2'b00};
    assign o_rx_ready   = r_rx_ready;
    assign o_imem_we    = r_imem_we;
    assign o_imem_wdata = r_word;
    assign o_cpu_hold   = r_cpu_hold;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader; covers the checksum build when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_boot_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] load_len;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] cpu_pc;
    logic [7:0] imem_addr;
    logic       imem_we;
    logic [31:0] imem_wdata;
    logic       cpu_hold;
    logic       done;
    logic       err;

    int n_total = 0;
    int n_bad   = 0;
    int we_cnt  = 0;
    int we_base = 0;

    imem_boot_loader dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_load_len  (load_len),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_rx_ready  (rx_ready),
        .i_cpu_pc    (cpu_pc),
        .o_imem_addr (imem_addr),
        .o_imem_we   (imem_we),
        .o_imem_wdata(imem_wdata),
        .o_cpu_hold  (cpu_hold),
        .o_done      (done),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) we_cnt = we_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic fired;
        int   n;
        rx_data  = b;
        rx_valid = 1'b1;
        fired    = 1'b0;
        n        = 0;
        while (!fired && n < 16) begin
            fired = rx_ready;
            n++;
            tick();
        end
        check("rx_handshake", 32'(fired), 32'd1);
    endtask

    task automatic do_start(input logic [6:0] len);
        start    = 1'b1;
        load_len = len;
        tick();
        start    = 1'b0;
    endtask

    // Ends a load after the last WRITE cycle; sends the checksum byte when enabled
    task automatic finish_load(input logic [7:0] xsum);
        rx_valid = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(xsum);
        rx_valid = 1'b0;
`else
        tick();
`endif
    endtask

    task automatic check_run(input string tag);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_err"},  32'(err), 32'd0);
        check({tag, "_we"},   32'(imem_we), 32'd0);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_hold"},  32'(cpu_hold), 32'd1);
        check({tag, "_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_we"},    32'(imem_we), 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_addr"},  32'(imem_addr), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_err"},   32'(err), 32'd0);
    endtask

    task automatic apply_reset();
        rx_valid = 1'b0;
        start    = 1'b0;
        rst      = 1'b1;
        #1;
        tick();
        rst      = 1'b0;
        tick();
        we_base  = we_cnt;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        load_len = '0;
        rx_data  = '0;
        rx_valid = 1'b0;
        cpu_pc   = '0;
        #2;
        check_reset_outs("por");
        apply_reset();
        check_reset_outs("idle");

        // Normal load, two words, rx_valid held high
        do_start(7'd2);
        check("nl_ready", 32'(rx_ready), 32'd1);
        check("nl_hold",  32'(cpu_hold), 32'd1);
        send_byte(8'h13); send_byte(8'h03); send_byte(8'h30); send_byte(8'h00);
        check("nl_w0_we",    32'(imem_we), 32'd1);
        check("nl_w0_ready", 32'(rx_ready), 32'd0);
        check("nl_w0_addr",  32'(imem_addr), 32'h00);
        check("nl_w0_data",  imem_wdata, 32'h0030_0313);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        check("nl_w1_we",   32'(imem_we), 32'd1);
        check("nl_w1_addr", 32'(imem_addr), 32'h04);
        check("nl_w1_data", imem_wdata, 32'h0010_0093);
        finish_load(8'hA3);
        check_run("nl_run");
        check("nl_we_count", 32'(we_cnt - we_base), 32'd2);
        cpu_pc = 8'h08;
        #1;
        check("nl_pc08", 32'(imem_addr), 32'h08);
        cpu_pc = 8'h13;
        #1;
        check("nl_pc13", 32'(imem_addr), 32'h13);

        // Gapped stream, rx_valid toggling, garbage data during gaps
        apply_reset();
        do_start(7'd1);
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'hAA + 8'(i * 8'h11);
            tick();
            if (i == 3) begin
                check("gap_we",   32'(imem_we), 32'd1);
                check("gap_data", imem_wdata, 32'hDDCC_BBAA);
                check("gap_addr", 32'(imem_addr), 32'h00);
            end else begin
                rx_valid = 1'b0;
                rx_data  = 8'hFF;
                tick();
            end
        end
        finish_load(8'h00);
        check_run("gap_run");
        check("gap_we_count", 32'(we_cnt - we_base), 32'd1);
        check("gap_data_hold", imem_wdata, 32'hDDCC_BBAA);

        // Bad lengths then recovery
        apply_reset();
        do_start(7'd0);
        check("bl0_err",   32'(err), 32'd1);
        check("bl0_hold",  32'(cpu_hold), 32'd1);
        check("bl0_ready", 32'(rx_ready), 32'd0);
        tick();
        do_start(7'd65);
        check("bl65_err",  32'(err), 32'd1);
        check("bl65_done", 32'(done), 32'd0);
        check("bl_we_count", 32'(we_cnt - we_base), 32'd0);
        do_start(7'd1);
        check("bl_rec_err",   32'(err), 32'd0);
        check("bl_rec_ready", 32'(rx_ready), 32'd1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("bl_rec_data", imem_wdata, 32'h4433_2211);
        finish_load(8'h44);
        check_run("bl_rec_run");

        // Mid-load asynchronous reset
        apply_reset();
        do_start(7'd3);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h05);
        rx_valid = 1'b0;
        check("ml_ready_mid", 32'(rx_ready), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outs("ml_rst");
        tick();
        rst = 1'b0;
        tick();
        we_base = we_cnt;

        // Start while receiving must not change the captured length
        do_start(7'd1);
        start    = 1'b1;
        load_len = 7'd3;
        tick();
        start    = 1'b0;
        check("ign_ready", 32'(rx_ready), 32'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        check("ign_data", imem_wdata, 32'h0403_0201);
        finish_load(8'h04);
        check_run("ign_run");
        check("ign_we_count", 32'(we_cnt - we_base), 32'd1);

        // Reload from RUN
        we_base = we_cnt;
        do_start(7'd1);
        check("rl_hold",  32'(cpu_hold), 32'd1);
        check("rl_done",  32'(done), 32'd0);
        check("rl_ready", 32'(rx_ready), 32'd1);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        check("rl_addr", 32'(imem_addr), 32'h00);
        check("rl_data", imem_wdata, 32'hDEAD_BEEF);
        finish_load(8'h22);
        check_run("rl_run");
        check("rl_we_count", 32'(we_cnt - we_base), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        do_start(7'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        check("cs_data", imem_wdata, 32'h0804_0201);
        rx_valid = 1'b0;
        tick();
        check("cs_check_ready", 32'(rx_ready), 32'd1);
        check("cs_check_hold",  32'(cpu_hold), 32'd1);
        send_byte(8'h0F);
        rx_valid = 1'b0;
        check_run("cs_ok");
        do_start(7'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        send_byte(8'h0E);
        rx_valid = 1'b0;
        check("cs_bad_err",  32'(err), 32'd1);
        check("cs_bad_hold", 32'(cpu_hold), 32'd1);
        check("cs_bad_done", 32'(done), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Boot-time program loader and access controller for the 256-byte instruction memory.
- Receives a program as a byte stream over a valid/ready handshake.
- Packs the bytes into 32-bit little-endian words and writes them at word-aligned byte addresses 0, 4, 8, and so on.
- Holds the core in stall while loading. Once the load completes, it hands the memory address port to the core's PC.

Parameters:
ADDR_W, 8, byte-address width of instruction memory
NUM_WORDS, 64, max program length in words (2^ADDR_W / 4)
LEN_W, 7, width of load_len (must hold NUM_WORDS)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  load request pulse, sampled in IDLE, RUN, ERR
load_len  input  LEN_W  program length in words, sampled when start is accepted
rx_data  input  8  incoming program byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader can accept a byte this cycle
cpu_pc  input  ADDR_W  core fetch address (byte address)
imem_addr  output  ADDR_W  address to instruction memory
imem_we  output  1  instruction memory write strobe
imem_wdata  output  32  word to write
cpu_hold  output  1  stall core / hold PC
done  output  1  program loaded, core running
err  output  1  load error latched

Behaviour:
- Reset (async, any state, including mid-load):
  - State goes to IDLE.
  - Outputs: cpu_hold=1, rx_ready=0, imem_we=0, imem_wdata=0, imem_addr=0, done=0, err=0.
  - Internal counters are cleared.
  - Partially written memory content is undefined.
- FSM states: IDLE, RECV, WRITE, (CHECK), RUN, ERR.
- IDLE:
  - start=1 with 1 <= load_len <= NUM_WORDS: capture len, word_cnt=0, byte_cnt=0, next state RECV.
  - start=1 with load_len=0 or load_len>NUM_WORDS: next state ERR.
- RECV:
  - rx_ready=1.
  - A byte is accepted when rx_valid & rx_ready. Byte k (0..3) goes to word bits [8k+7:8k].
  - Acceptance of byte 3 moves to WRITE.
  - rx_valid=0 simply waits; there is no timeout.
- WRITE (exactly 1 cycle):
  - rx_ready=0, imem_we=1, imem_addr=word_cnt*4, imem_wdata=assembled word.
  - imem_we is therefore high the cycle after the 4th byte handshake.
  - Then word_cnt increments and byte_cnt clears.
  - If the written word was word len-1: go to RUN (or CHECK, see Optional Feature). Otherwise go back to RECV.
- RUN:
  - cpu_hold=0, done=1, imem_we=0.
  - imem_addr = cpu_pc, combinational pass-through with zero latency; low 2 bits unmodified.
- ERR:
  - err=1, cpu_hold=1, done=0.
  - Left only by start with a valid load_len, which goes to RECV and clears err.
- start handling:
  - Ignored in RECV and WRITE.
  - In RUN, a valid start re-enters RECV: cpu_hold=1 and done=0 from the next cycle.
  - In RUN, an invalid load_len goes to ERR.
- Address muxing: in every state except RUN, imem_addr is driven by the loader (word_cnt*4). It never exceeds 4*(NUM_WORDS-1), so there is no wrap.
- rx_ready is registered state-decoded, never combinationally dependent on rx_valid.
- cpu_hold=1 in every state except RUN.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN:
- When defined:
  - After the last WRITE, the FSM enters CHECK with rx_ready=1.
  - One extra byte is accepted and compared with the XOR of all program bytes received in this load.
  - Match: go to RUN.
  - Mismatch: go to ERR, with err=1 and the core still held.
- When undefined:
  - The CHECK state and the XOR register do not exist.
  - The last WRITE goes directly to RUN.

Test Plan:
- Normal load:
  - Stimulus: reset, start with load_len=2, bytes 13 03 30 00 93 00 10 00 with rx_valid held high.
  - Required: imem_we pulses with addr 0x00, data 0x00300313; then addr 0x04, data 0x00100093.
  - Then done=1 and cpu_hold=0, and cpu_pc=0x08 gives imem_addr=0x08 in the same cycle.
- Gapped stream: rx_valid toggled 1/0 every cycle for load_len=1 -> only 4 handshakes counted, single imem_we, word assembled correctly.
- Bad length:
  - Stimulus: start with load_len=0, then separately load_len=65.
  - Required: err=1, cpu_hold=1, no imem_we.
  - Then start with load_len=1 plus 4 bytes: err clears and the FSM reaches RUN.
- Mid-load reset and start ignored:
  - Stimulus: start with load_len=3, 5 bytes accepted, reset pulse asserted asynchronously mid-cycle.
  - Required: all outputs at reset values immediately. A start issued while in RECV of a fresh load is ignored: len is unchanged.
- Reload from RUN: after a completed load, start with load_len=1 -> cpu_hold=1 and done=0 the next cycle, new word written at addr 0x00, then RUN again.
- With IMEM_LOADER_CHECKSUM_EN:
  - load_len=1, bytes 01 02 04 08 followed by checksum 0x0F -> RUN.
  - Same bytes followed by 0x0E -> err=1 with cpu_hold=1.
